// File: rtl/audio_i2s_tx_if.sv
// audio_i2s_tx_if: stereo sample-pair push channel into the I2S transmitter.
// Signals: iL_DATA / iR_DATA sample pair, iVALID from source, oREADY from FIFO.
interface audio_i2s_tx_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] iL_DATA;
    logic [DATA_WIDTH-1:0] iR_DATA;
    logic                  iVALID;
    logic                  oREADY;

    modport master (
        output iL_DATA,
        output iR_DATA,
        output iVALID,
        input  oREADY
    );

    modport slave (
        input  iL_DATA,
        input  iR_DATA,
        input  iVALID,
        output oREADY
    );
endinterface

// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: FIFO-fed stereo serialiser, I2S or left-justified, MSB first.
// Ports: iCLK, iRST_N (async low), iENABLE, iMODE, src (pair push, slave),
//        oAUD_BCK/oAUD_LRCK/oAUD_DATA, oUNDERRUN pulse, oFIFO_LEVEL.
module audio_i2s_tx #(
    parameter int DATA_WIDTH = 16,
    parameter int SLOT_WIDTH = 32,
    parameter int BCK_HALF   = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       iCLK,
    input  logic                       iRST_N,
    input  logic                       iENABLE,
    input  logic                       iMODE,
    audio_i2s_tx_if.slave              src,
    output logic                       oAUD_BCK,
    output logic                       oAUD_LRCK,
    output logic                       oAUD_DATA,
    output logic                       oUNDERRUN,
    output logic [$clog2(FIFO_DEPTH):0] oFIFO_LEVEL
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = AW + 1;
    localparam int NW  = $clog2(2 * SLOT_WIDTH);
    localparam int DVW = (BCK_HALF > 1) ? $clog2(BCK_HALF) : 1;
    localparam int PW  = 2 * DATA_WIDTH;

    localparam logic [NW-1:0]  SLOT_N   = NW'(SLOT_WIDTH);
    localparam logic [NW-1:0]  LAST_N   = NW'(2 * SLOT_WIDTH - 1);
    localparam logic [NW-1:0]  DW_N     = NW'(DATA_WIDTH);
    localparam logic [DVW-1:0] DIV_LAST = DVW'(BCK_HALF - 1);
    localparam logic [LW-1:0]  FULL_N   = LW'(FIFO_DEPTH);
    localparam bit             SAME_W   = (SLOT_WIDTH == DATA_WIDTH);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state_q;
    state_t state_d;

    // FIFO
    logic [PW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [LW-1:0] lvl_q;
    logic [PW-1:0] rd_word;
    logic          empty;
    logic          ready;
    logic          push;
    logic          pop;

    // Timing counters
    logic [DVW-1:0] div_q;
    logic [NW-1:0]  n_q;
    logic           bck_q;
    logic           tick;
    logic           fall;
    logic           wrap;
    logic           load;

    // Current frame
    logic [DATA_WIDTH-1:0] l_q;
    logic [DATA_WIDTH-1:0] r_q;
    logic                  mode_q;
    logic                  prev_q;
    logic                  urun_q;

    // Serialiser
    logic                  lr;
    logic [NW-1:0]         p;
    logic [DATA_WIDTH-1:0] w;
    logic [DATA_WIDTH-1:0] sh_lj;
    logic [DATA_WIDTH-1:0] sh_i2s;
    logic                  bit_lj;
    logic                  bit_i2s;
    logic                  sdata;

    assign empty      = (lvl_q == '0);
    assign ready      = (lvl_q != FULL_N);
    assign src.oREADY = ready;
    assign push       = src.iVALID && ready;
    assign pop        = load && !empty;
    assign rd_word    = mem[rd_q];

    always_ff @(posedge iCLK) begin
        if (push) begin
            mem[wr_q] <= {src.iL_DATA, src.iR_DATA};
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
        end else begin
            if (push) begin
                wr_q <= wr_q + 1'b1;
            end
            if (pop) begin
                rd_q <= rd_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   lvl_q <= lvl_q + 1'b1;
                2'b01:   lvl_q <= lvl_q - 1'b1;
                default: lvl_q <= lvl_q;
            endcase
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A frame load happens on the start edge and on every wrapping
    // BCK fall; a wrap with iENABLE low parks the block instead.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        tick    = (state_q == RUN) && (div_q == DIV_LAST);
        fall    = tick && bck_q;
        wrap    = fall && (n_q == LAST_N);
        unique case (state_q)
            IDLE: begin
                if (iENABLE) begin
                    state_d = RUN;
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (wrap) begin
                    if (iENABLE) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            div_q <= '0;
            bck_q <= 1'b0;
            n_q   <= '0;
        end else if (state_q == IDLE) begin
            div_q <= '0;
            bck_q <= 1'b0;
            n_q   <= '0;
        end else if (tick) begin
            div_q <= '0;
            bck_q <= !bck_q;
            if (fall) begin
                n_q <= wrap ? '0 : n_q + 1'b1;
            end
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    // prev_q keeps the last right-channel LSB for the I2S delayed bit;
    // a start from IDLE has no previous slot, so it is cleared.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            l_q    <= '0;
            r_q    <= '0;
            mode_q <= 1'b0;
            prev_q <= 1'b0;
            urun_q <= 1'b0;
        end else begin
            urun_q <= load && empty;
            if (load) begin
                mode_q <= iMODE;
                prev_q <= (state_q == RUN) && r_q[0];
                l_q    <= empty ? '0 : rd_word[PW-1:DATA_WIDTH];
                r_q    <= empty ? '0 : rd_word[DATA_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        lr      = (n_q >= SLOT_N);
        p       = lr ? (n_q - SLOT_N) : n_q;
        w       = lr ? r_q : l_q;
        sh_lj   = w << p;
        sh_i2s  = w << (p - 1'b1);
        bit_lj  = (p < DW_N) && sh_lj[DATA_WIDTH-1];
        bit_i2s = 1'b0;
        if (p == '0) begin
            bit_i2s = SAME_W && (lr ? l_q[0] : prev_q);
        end else if (p <= DW_N) begin
            bit_i2s = sh_i2s[DATA_WIDTH-1];
        end
        sdata = mode_q ? bit_lj : bit_i2s;
    end

    assign oAUD_BCK    = bck_q;
    assign oAUD_LRCK   = (state_q == RUN) && lr;
    assign oAUD_DATA   = (state_q == RUN) && sdata;
    assign oUNDERRUN   = urun_q;
    assign oFIFO_LEVEL = lvl_q;

endmodule

// File: doc/audio_i2s_tx.md
# audio_i2s_tx

Parametrised serial audio transmitter for the codec DAC path. It generates BCK and LRCK from the single system clock with enable-gated clock-enable counters, not derived clocks. It accepts stereo sample pairs over a valid/ready handshake into a small FIFO and serialises them MSB-first in I2S or left-justified format. FIFO underruns are flagged. Sample sources such as tone tables and memory readers push into it instead of driving the serial lines directly.

## Interface
Parameters:
- DATA_WIDTH, 16: sample bits per channel.
- SLOT_WIDTH, 32: BCK periods per channel slot; must be >= DATA_WIDTH.
- BCK_HALF, 3: iCLK cycles per BCK half-period. At 18.432 MHz with 32-bit slots this gives 48 kHz.
- FIFO_DEPTH, 4: sample-pair entries; power of two, >= 2.

Ports:
- iCLK, in, 1: system clock. One clock only; reset is asynchronous and active-low.
- iRST_N, in, 1: asynchronous active-low reset.
- iENABLE, in, 1: run request.
- iMODE, in, 1: 0 = I2S (MSB one BCK after the LRCK edge), 1 = left-justified.
- iL_DATA, in, DATA_WIDTH: left sample, two's complement.
- iR_DATA, in, DATA_WIDTH: right sample.
- iVALID, in, 1: pair valid.
- oREADY, out, 1: FIFO not full.
- oAUD_BCK, out, 1: bit clock.
- oAUD_LRCK, out, 1: 0 = left slot, 1 = right slot.
- oAUD_DATA, out, 1: serial data.
- oUNDERRUN, out, 1: one-cycle pulse when a frame loads with the FIFO empty.
- oFIFO_LEVEL, out, log2(FIFO_DEPTH)+1: current number of FIFO entries.

## Operation
- **Push:** a pair is written on every iCLK edge where iVALID && oREADY. oREADY = (level != FIFO_DEPTH), combinational from the registered level. A push while full is dropped; the source must hold iVALID.
- **States:**
  - IDLE: BCK, LRCK and DATA are held 0; the counters are cleared.
  - IDLE -> RUN: on the edge where iENABLE=1 is sampled. That edge performs the frame load.
  - RUN -> IDLE: only at a frame boundary with iENABLE=0. A frame in progress always completes.
- **Frame load:** occurs at IDLE->RUN, and at every BCK falling edge that wraps the bit position to 0.
  - Pops one pair if the FIFO is non-empty.
  - If the FIFO is empty, loads L=R=0 and pulses oUNDERRUN for one cycle.
  - Latches iMODE into the frame mode. iMODE changes mid-frame do not affect the current frame.
- **BCK:** a divider counts 0..BCK_HALF-1 and toggles BCK at BCK_HALF-1. BCK rises first. Data and LRCK change only at BCK falling edges, so the DAC samples on the rising edge.
- **Bit position:** n runs 0..2*SLOT_WIDTH-1 and advances at each BCK falling edge.
  - LRCK = (n >= SLOT_WIDTH).
  - Slot position p = n mod SLOT_WIDTH.
  - w = the current channel word.
- **Left-justified mode:**
  - DATA = w[DATA_WIDTH-1-p] for p < DATA_WIDTH.
  - DATA = 0 otherwise.
- **I2S mode:**
  - For 1 <= p <= DATA_WIDTH: DATA = w[DATA_WIDTH-p].
  - For p = 0: DATA = the LSB of the previous slot's word if SLOT_WIDTH == DATA_WIDTH, else 0. In the first frame after IDLE it is 0.
  - DATA = 0 otherwise.
- **FIFO boundaries:**
  - Push and pop in the same cycle: level is unchanged.
  - Push into an empty FIFO on a load edge: the load sees empty and underruns. There is no bypass.
  - Pointers wrap modulo FIFO_DEPTH.
- **Reset mid-operation:** returns to IDLE immediately and empties the FIFO.

## Timing
- Reset values:
  - oAUD_BCK = 0, oAUD_LRCK = 0, oAUD_DATA = 0.
  - oUNDERRUN = 0, oFIFO_LEVEL = 0.
  - oREADY = 1 (FIFO empty).
- Frame period is 4*SLOT_WIDTH*BCK_HALF iCLK cycles; 384 with the defaults.
- The first BCK rising edge comes BCK_HALF cycles after the IDLE->RUN edge.
- The first valid data bit is presented at the IDLE->RUN edge in left-justified mode. In I2S mode it comes one BCK period later.
- Push to FIFO visibility: oFIFO_LEVEL updates on the edge after the push.
- oUNDERRUN fires at most once per frame, aligned to the load edge.
- The LRCK edge and the slot's first DATA bit change on the same iCLK edge as a BCK falling edge.

## Test plan
- **Reset:** hold iRST_N=0 with random inputs. Expected: all outputs at their reset values, oREADY=1. Deasserting reset with iENABLE=0 keeps BCK/LRCK/DATA at 0.
- **Left-justified frame:** iMODE=1, push L=16'hA5A5, R=16'h5A5A, enable. Expected:
  - 64 BCK periods per 384 cycles.
  - Left slot bits 1010_0101_1010_0101 then 16 zeros, LRCK=0.
  - Right slot 0101_1010_0101_1010 then zeros, LRCK=1.
  - oUNDERRUN=0.
- **I2S frame:** iMODE=0, same data. Expected:
  - DATA=0 at p=0 of the left slot (first frame).
  - MSB 1 appears at p=1 and the pattern is shifted one BCK later.
  - With SLOT_WIDTH=16, the right slot's p=0 carries L's LSB (1).
- **Underrun:** enable with the FIFO empty. Expected: all-zero DATA, one oUNDERRUN pulse per frame. Push one pair mid-frame; expected: it is played in the next frame with no pulse for that frame.
- **Backpressure:** hold iVALID=1 for 6 cycles with 6 distinct pairs while disabled. Expected: oFIFO_LEVEL goes to 4, oREADY=0, the extra pushes are dropped. Enabling then plays the first 4 pairs in order and oREADY rises after the first pop.
- **Mid-frame changes:**
  - Toggle iMODE mid-frame. Expected: the format changes only from the next frame.
  - Drop iENABLE mid-frame. Expected: the frame completes, then the block idles.
  - Pulse iRST_N mid-frame. Expected: outputs clear immediately and the FIFO is emptied.
